// File: rtl/rate_restore.sv
// rate_restore: captures a burst of signed samples arriving at the fast
// output_clk rate into a buffer, then replays them one sample per rising
// edge of the asynchronous slow_clk reference. Burst length is checked
// against point_num; long bursts are truncated and short bursts still drain.
module rate_restore #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              output_clk,
    input  logic              rst_n,
    input  logic              slow_clk,
    input  logic [15:0]       point_num,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy,
    output logic              len_err,
    output logic              ovf_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra pointer bit so a full-depth burst length is representable.
    localparam int PW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Saturate the requested burst length into 1..DEPTH.
    function automatic logic [PW-1:0] clamp_len(input logic [15:0] pn);
        if (pn == 16'd0)
            clamp_len = PW'(1);
        else if (32'(pn) > 32'(DEPTH))
            clamp_len = PW'(DEPTH);
        else
            clamp_len = PW'(pn);
    endfunction

    state_t                   r_state, w_nxt_state;
    logic [PW-1:0]            r_wr_ptr, w_nxt_wr_ptr;
    logic [PW-1:0]            r_rd_ptr, w_nxt_rd_ptr;
    logic [PW-1:0]            r_len, w_nxt_len;
    logic [PW-1:0]            r_len_tgt, w_nxt_len_tgt;
    logic                     r_dout_valid, w_nxt_dout_valid;
    logic                     r_dout_last, w_nxt_dout_last;
    logic                     r_len_err, w_nxt_len_err;
    logic                     r_ovf_err, w_nxt_ovf_err;
    logic                     r_s_ready, w_nxt_s_ready;
    logic                     w_wr_en, w_rd_en, w_accept;
    logic [PW-1:0]            w_tgt, w_cnt;

    logic                     r_slow_s1, r_slow_s2, r_slow_prev;
    logic                     w_slow_edge;

    logic signed [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic signed [DATA_W-1:0] r_dout;

    // Two-flop synchroniser plus edge register for the slow rate reference.
    always_ff @(posedge output_clk) begin
        if (!rst_n) begin
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_prev <= 1'b0;
        end else begin
            r_slow_s1   <= slow_clk;
            r_slow_s2   <= r_slow_s1;
            r_slow_prev <= r_slow_s2;
        end
    end

    assign w_slow_edge = r_slow_s2 & ~r_slow_prev;
    assign w_accept    = s_valid & r_s_ready;
    assign w_tgt       = clamp_len(point_num);
    assign w_cnt       = r_wr_ptr + PW'(1);

    // Next-state, pointer, flag and output-control logic.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_wr_ptr     = r_wr_ptr;
        w_nxt_rd_ptr     = r_rd_ptr;
        w_nxt_len        = r_len;
        w_nxt_len_tgt    = r_len_tgt;
        w_nxt_dout_valid = r_dout_valid;
        w_nxt_dout_last  = r_dout_last;
        w_nxt_len_err    = r_len_err;
        w_nxt_ovf_err    = r_ovf_err;
        w_wr_en          = 1'b0;
        w_rd_en          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_wr_en       = 1'b1;
                    w_nxt_wr_ptr  = w_cnt;
                    w_nxt_len_tgt = w_tgt;
                    if (s_last) begin
                        w_nxt_len   = PW'(1);
                        w_nxt_state = ST_DRAIN;
                        if (w_tgt != PW'(1))
                            w_nxt_len_err = 1'b1;
                    end else if (w_tgt == PW'(1)) begin
                        // Single-beat target already met: drop the rest.
                        w_nxt_len     = PW'(1);
                        w_nxt_len_err = 1'b1;
                        w_nxt_state   = ST_DISCARD;
                    end else begin
                        w_nxt_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_wr_en      = 1'b1;
                    w_nxt_wr_ptr = w_cnt;
                    if (s_last) begin
                        w_nxt_len   = w_cnt;
                        w_nxt_state = ST_DRAIN;
                        if (w_cnt != r_len_tgt)
                            w_nxt_len_err = 1'b1;
                    end else if (w_cnt == r_len_tgt) begin
                        w_nxt_len     = r_len_tgt;
                        w_nxt_len_err = 1'b1;
                        w_nxt_state   = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                // Excess beats are consumed silently until the burst ends.
                if (s_valid && s_last)
                    w_nxt_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (s_valid)
                    w_nxt_ovf_err = 1'b1;
                if (w_slow_edge) begin
                    if (r_rd_ptr != r_len) begin
                        w_rd_en          = 1'b1;
                        w_nxt_dout_valid = 1'b1;
                        w_nxt_dout_last  = (r_rd_ptr == r_len - PW'(1));
                        w_nxt_rd_ptr     = r_rd_ptr + PW'(1);
                    end else begin
                        // Last sample has had its full slow period; retire.
                        w_nxt_dout_valid = 1'b0;
                        w_nxt_dout_last  = 1'b0;
                        w_nxt_wr_ptr     = '0;
                        w_nxt_rd_ptr     = '0;
                        w_nxt_state      = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        w_nxt_s_ready = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_FILL);
    end

    // Control state register.
    always_ff @(posedge output_clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_len        <= '0;
            r_len_tgt    <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_len_err    <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_wr_ptr     <= w_nxt_wr_ptr;
            r_rd_ptr     <= w_nxt_rd_ptr;
            r_len        <= w_nxt_len;
            r_len_tgt    <= w_nxt_len_tgt;
            r_dout_valid <= w_nxt_dout_valid;
            r_dout_last  <= w_nxt_dout_last;
            r_len_err    <= w_nxt_len_err;
            r_ovf_err    <= w_nxt_ovf_err;
            r_s_ready    <= w_nxt_s_ready;
        end
    end

    // Buffer write port; contents survive reset.
    always_ff @(posedge output_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= s_data;
    end

    // Registered read port doubles as the held output sample.
    always_ff @(posedge output_clk) begin
        if (!rst_n)
            r_dout <= '0;
        else if (w_rd_en)
            r_dout <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    assign s_ready    = r_s_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = (r_state != ST_IDLE);
    assign len_err    = r_len_err;
    assign ovf_err    = r_ovf_err;

endmodule

// File: tb/tb_rate_restore.sv
// Directed bench for rate_restore: nominal, short, long, overflow,
// full-depth and mid-drain reset bursts with hand-computed expectations.
module tb_rate_restore;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              output_clk = 1'b0;
    logic              slow_clk   = 1'b0;
    logic              rst_n      = 1'b0;
    logic [15:0]       point_num  = 16'd0;
    logic              s_valid    = 1'b0;
    logic              s_last     = 1'b0;
    logic [DATA_W-1:0] s_data     = '0;
    logic              s_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_last;
    logic              busy;
    logic              len_err;
    logic              ovf_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] got_d [0:63];
    logic              got_l [0:63];
    int                got_n;
    logic              got_to;

    rate_restore #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .output_clk (output_clk),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .point_num  (point_num),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .busy       (busy),
        .len_err    (len_err),
        .ovf_err    (ovf_err)
    );

    always #5  output_clk = ~output_clk;
    always #50 slow_clk   = ~slow_clk;

    task automatic do_reset();
        @(negedge output_clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge output_clk);
        rst_n = 1'b1;
        @(negedge output_clk);
    endtask

    task automatic send_burst(input int n, input int pn, input int lastpos, input int base);
        @(negedge output_clk);
        point_num = pn[15:0];
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(base + i);
            s_last  = (i == lastpos - 1);
            @(negedge output_clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Capture one held sample per slow period until dout_valid drops.
    task automatic collect(input int ovf_pulse);
        logic started;
        started = 1'b0;
        got_n   = 0;
        got_to  = 1'b0;
        for (int k = 0; k < 2 * DEPTH + 20; k++) begin
            @(negedge slow_clk);
            if (dout_valid) begin
                started = 1'b1;
                if (got_n < 64) begin
                    got_d[got_n] = dout;
                    got_l[got_n] = dout_last;
                end
                got_n++;
                if (ovf_pulse != 0 && got_n == 1) begin
                    s_valid = 1'b1;
                    s_data  = DATA_W'(99);
                    @(posedge output_clk);
                    #1;
                    s_valid = 1'b0;
                end
            end else if (started) begin
                return;
            end
        end
        got_to = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge output_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge output_clk);
        checks++;
        if ({s_ready, dout_valid, dout_last, busy, len_err, ovf_err} !== 6'b0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b busy=%b le=%b oe=%b dout=%0d want all 0",
                     s_ready, dout_valid, dout_last, busy, len_err, ovf_err, dout);
        end
        rst_n = 1'b1;
        @(negedge output_clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got s_ready=%b busy=%b want 1 0", s_ready, busy);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        send_burst(8, 8, 8, 1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy got %b want 1", busy);
        end
        collect(0);
        checks++;
        if (got_to !== 1'b0 || got_n !== 8) begin
            errors++;
            $display("FAIL nominal_count got %0d timeout=%b want 8", got_n, got_to);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(i + 1) || got_l[i] !== (i == 7)) begin
                errors++;
                $display("FAIL nominal_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], i + 1, (i == 7));
            end
        end
        checks++;
        if (len_err !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL nominal_after got le=%b rdy=%b busy=%b v=%b want 0 1 0 0",
                     len_err, s_ready, busy, dout_valid);
        end
        checks++;
        if (dout !== DATA_W'(8)) begin
            errors++;
            $display("FAIL nominal_hold got %0d want 8", dout);
        end
    endtask

    task automatic test_short();
        do_reset();
        send_burst(5, 8, 5, 1);
        collect(0);
        checks++;
        if (got_to !== 1'b0 || got_n !== 5) begin
            errors++;
            $display("FAIL short_count got %0d timeout=%b want 5", got_n, got_to);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(i + 1) || got_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL short_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], i + 1, (i == 4));
            end
        end
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL short_len_err got %b want 1", len_err);
        end
    endtask

    task automatic test_long();
        do_reset();
        send_burst(6, 4, 6, 1);
        collect(0);
        checks++;
        if (got_to !== 1'b0 || got_n !== 4) begin
            errors++;
            $display("FAIL long_count got %0d timeout=%b want 4", got_n, got_to);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(i + 1) || got_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL long_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], i + 1, (i == 3));
            end
        end
        checks++;
        if (len_err !== 1'b1 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL long_flags got le=%b oe=%b want 1 0", len_err, ovf_err);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_burst(6, 6, 6, 21);
        collect(1);
        checks++;
        if (got_to !== 1'b0 || got_n !== 6) begin
            errors++;
            $display("FAIL ovf_count got %0d timeout=%b want 6", got_n, got_to);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(21 + i) || got_l[i] !== (i == 5)) begin
                errors++;
                $display("FAIL ovf_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], 21 + i, (i == 5));
            end
        end
        checks++;
        if (ovf_err !== 1'b1 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags got oe=%b le=%b want 1 0", ovf_err, len_err);
        end
    endtask

    task automatic test_full_depth();
        do_reset();
        send_burst(DEPTH, DEPTH, DEPTH, 100);
        collect(0);
        checks++;
        if (got_to !== 1'b0 || got_n !== DEPTH) begin
            errors++;
            $display("FAIL full_count got %0d timeout=%b want %0d", got_n, got_to, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(100 + i) || got_l[i] !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL full_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], 100 + i, (i == DEPTH - 1));
            end
        end
        checks++;
        if (len_err !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL full_flags got le=%b oe=%b want 0 0", len_err, ovf_err);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic found;
        do_reset();
        send_burst(8, 8, 8, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge slow_clk);
            if (dout_valid && dout == DATA_W'(2))
                found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL middrain_reach got dout=%0d v=%b want 2 1", dout, dout_valid);
        end
        rst_n = 1'b0;
        @(posedge output_clk);
        #1;
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL middrain_reset got dout=%0d v=%b l=%b busy=%b rdy=%b want 0 0 0 0 0",
                     dout, dout_valid, dout_last, busy, s_ready);
        end
        rst_n = 1'b1;
        @(posedge output_clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL middrain_ready got %b want 1", s_ready);
        end
        send_burst(3, 3, 3, 10);
        collect(0);
        checks++;
        if (got_to !== 1'b0 || got_n !== 3) begin
            errors++;
            $display("FAIL middrain_count got %0d timeout=%b want 3", got_n, got_to);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_d[i] !== DATA_W'(10 + i) || got_l[i] !== (i == 2)) begin
                errors++;
                $display("FAIL middrain_sample%0d got %0d last=%b want %0d last=%b",
                         i, got_d[i], got_l[i], 10 + i, (i == 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_overflow();
        test_full_depth();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
